// File: rtl/store_control_if.sv
// IO write channel between the store path and the IO block.
// The store path is the master; the IO block pops the head with io_wready.
interface store_control_if;
    logic        io_wvalid;
    logic        io_wready;
    logic [31:0] io_waddr;
    logic [31:0] io_wdata;
    logic [3:0]  io_wstrb;

    modport master (
        output io_wvalid,
        output io_waddr,
        output io_wdata,
        output io_wstrb,
        input  io_wready
    );

    modport slave (
        input  io_wvalid,
        input  io_waddr,
        input  io_wdata,
        input  io_wstrb,
        output io_wready
    );
endinterface

// File: rtl/store_control.sv
// Memory-stage store path: SB/SH/SW decode, lane alignment, DMEM/IMEM
// write enables and an IO store FIFO drained over a valid/ready channel.
module store_control #(
    parameter int IO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    input  logic [31:0] rs2_data,
    output logic [31:0] mem_din,
    output logic [3:0]  dmem_we,
    output logic [3:0]  imem_we,
    output logic        stall,
    output logic        misalign_err,
    store_control_if.master io
);
    localparam int PW = $clog2(IO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [4:0] OPC_STORE_5 = 5'b01000;
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } io_ent_t;

    io_ent_t         fifo_q [IO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            is_store;
    logic            misalign;
    logic [3:0]      strb_raw;
    logic [3:0]      strb;
    logic            hit_dmem;
    logic            hit_imem;
    logic            hit_io;
    logic            io_store;
    logic            full;
    logic            push;
    logic            pop;
    logic            unused_ok;

    assign unused_ok = ^{inst[31:15], inst[11:7], inst[1:0],
                         pc[31], pc[29:0]};

    always_comb begin
        is_store = inst_valid && (inst[6:2] == OPC_STORE_5);
        strb_raw = 4'b0000;
        mem_din  = rs2_data;
        misalign = 1'b0;
        unique case (inst[14:12])
            F3_SB: begin
                strb_raw = 4'b0001 << addr[1:0];
                mem_din  = {4{rs2_data[7:0]}};
            end
            F3_SH: begin
                strb_raw = addr[1] ? 4'b1100 : 4'b0011;
                mem_din  = {2{rs2_data[15:0]}};
                misalign = addr[0];
            end
            F3_SW: begin
                strb_raw = 4'b1111;
                misalign = (addr[1:0] != 2'b00);
            end
            default: begin
                strb_raw = 4'b0000;
            end
        endcase
        if (!is_store) begin
            strb_raw = 4'b0000;
            misalign = 1'b0;
        end
        strb = misalign ? 4'b0000 : strb_raw;
    end

    // 0011 decodes as both DMEM and IMEM, so regions are not exclusive
    assign hit_dmem = (addr[31:28] ==? 4'b00?1);
    assign hit_imem = (addr[31:28] ==? 4'b001?);
    assign hit_io   = (addr[31:28] == 4'b1000);

    assign dmem_we  = hit_dmem ? strb : 4'b0000;
    assign imem_we  = (hit_imem && pc[30]) ? strb : 4'b0000;

    assign io_store = hit_io && (strb != 4'b0000);
    assign full     = (count == CW'(IO_DEPTH));
    assign stall    = io_store && full;
    assign push     = io_store && !full && !rst;
    assign pop      = (count != '0) && io.io_wready;

    assign io.io_wvalid = (count != '0);
    assign io.io_waddr  = {fifo_q[rd_ptr].waddr, 2'b00};
    assign io.io_wdata  = fifo_q[rd_ptr].wdata;
    assign io.io_wstrb  = fifo_q[rd_ptr].wstrb;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr] <= '{waddr: addr[31:2],
                                wdata: mem_din,
                                wstrb: strb};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            misalign_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (misalign) misalign_err <= 1'b1;
        end
    end
endmodule
